// File: rtl/wptr_full_pkg.sv
// Constants shared by the write- and read-side pointer blocks of the async FIFO.
package wptr_full_pkg;

  localparam int FIFO_ADDR      = 3;
  localparam int FIFO_AFULL_THR = 6;

endpackage

// File: rtl/wptr_full_gray2bin.sv
// Purely combinational Gray-to-binary converter, shared by both pointer blocks.
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at and above it
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer and flag logic of an asynchronous FIFO: Gray write
// pointer, full / almost-full flags, fill level and a sticky overflow flag.
module wptr_full
  import wptr_full_pkg::*;
#(
  parameter int ADDR      = FIFO_ADDR,
  parameter int AFULL_THR = FIFO_AFULL_THR
) (
  input  logic            wclk,
  input  logic            wrst,
  input  logic            winc,
  input  logic [ADDR:0]   wq2_rptr,
  input  logic            woverflow_clr,
  output logic [ADDR-1:0] waddr,
  output logic [ADDR:0]   wptr,
  output logic            wfull,
  output logic            walmost_full,
  output logic [ADDR:0]   wlevel,
  output logic            woverflow
);

  localparam logic [ADDR+1:0] AFULL_THR_W = (ADDR+2)'(AFULL_THR);

  logic [ADDR:0] wbin_q, wbin_d;
  logic [ADDR:0] wptr_q, wptr_d;
  logic [ADDR:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          woverflow_q, woverflow_d;

  logic          accept_s;
  logic [ADDR:0] wbinnext_s;
  logic [ADDR:0] wgraynext_s;
  logic [ADDR:0] rq2bin_s;
  logic [ADDR:0] wfill_s;

  gray2bin #(.W(ADDR+1)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rq2bin_s)
  );

  // Next-state: pointer advance, flags computed from the post-write pointer
  always_comb begin
    accept_s       = winc & ~wfull_q;
    wbinnext_s     = wbin_q + {{ADDR{1'b0}}, accept_s};
    wgraynext_s    = (wbinnext_s >> 1) ^ wbinnext_s;
    wfill_s        = wbinnext_s - rq2bin_s;
    wbin_d         = wbinnext_s;
    wptr_d         = wgraynext_s;
    wlevel_d       = wfill_s;
    // Full when the write pointer has lapped the synchronized read pointer
    wfull_d        = (wgraynext_s == {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]});
    walmost_full_d = ({1'b0, wfill_s} >= AFULL_THR_W);
    if (winc && wfull_q) begin
      woverflow_d = 1'b1;
    end else if (woverflow_clr) begin
      woverflow_d = 1'b0;
    end else begin
      woverflow_d = woverflow_q;
    end
  end

  // State registers, cleared asynchronously on wrst
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign waddr        = wbin_q[ADDR-1:0];
  assign wptr         = wptr_q;
  assign wlevel       = wlevel_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: table-driven fill/overflow/drain vectors
// plus model-driven reset and wrap sequences, compared through a queue.
module tb_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst, winc, woverflow_clr;
  logic [3:0] wq2_rptr;
  logic [2:0] waddr;
  logic [3:0] wptr, wlevel;
  logic       wfull, walmost_full, woverflow;

  always #5 wclk = ~wclk;

  wptr_full dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .winc          (winc),
    .wq2_rptr      (wq2_rptr),
    .woverflow_clr (woverflow_clr),
    .waddr         (waddr),
    .wptr          (wptr),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .wlevel        (wlevel),
    .woverflow     (woverflow)
  );

  typedef struct {
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       full;
    logic       af;
    logic [3:0] level;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic       winc;
    logic [3:0] rptr;
    logic       clr;
    exp_t       e;
  } vec_t;

  vec_t vecs[15];
  exp_t sb[$];
  exp_t none;
  int   checks = 0;
  int   errors = 0;
  int   m_bin, m_rbin;
  logic m_full, m_ovf;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int g2b(input logic [3:0] g);
    int b = 0;
    for (int i = 3; i >= 0; i--) b = (b << 1) | ((b & 1) ^ int'(g[i]));
    return b;
  endfunction

  function automatic vec_t mk(input logic wi, input logic [3:0] rp, input logic cl,
                              input logic [3:0] p, input logic [2:0] a, input logic f,
                              input logic af, input logic [3:0] l, input logic o);
    vec_t v;
    v.winc = wi; v.rptr = rp; v.clr = cl;
    v.e.wptr = p; v.e.waddr = a; v.e.full = f; v.e.af = af; v.e.level = l; v.e.ovf = o;
    return v;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".wptr"},  {4'h0, wptr},  {4'h0, e.wptr});
    check({tag, ".waddr"}, {5'h0, waddr}, {5'h0, e.waddr});
    check({tag, ".wfull"}, {7'h0, wfull}, {7'h0, e.full});
    check({tag, ".afull"}, {7'h0, walmost_full}, {7'h0, e.af});
    check({tag, ".wlevel"},{4'h0, wlevel},{4'h0, e.level});
    check({tag, ".ovf"},   {7'h0, woverflow}, {7'h0, e.ovf});
  endtask

  // One clock: drive inputs, predict with the model, compare after the edge
  task automatic step(input logic i_winc, input logic [3:0] i_rptr, input logic i_clr,
                      input logic use_tab, input exp_t tab_e, input string tag);
    exp_t e;
    int   acc, nb, fill;
    winc = i_winc; wq2_rptr = i_rptr; woverflow_clr = i_clr;
    m_rbin  = g2b(i_rptr);
    acc     = (i_winc && !m_full) ? 1 : 0;
    nb      = (m_bin + acc) % 16;
    fill    = (nb - m_rbin + 16) % 16;
    e.wptr  = 4'(nb ^ (nb >> 1));
    e.waddr = 3'(nb % 8);
    e.full  = (fill == 8);
    e.af    = (fill >= 6);
    e.level = 4'(fill);
    e.ovf   = (i_winc && m_full) ? 1'b1 : (i_clr ? 1'b0 : m_ovf);
    m_bin = nb; m_full = e.full; m_ovf = e.ovf;
    sb.push_back(use_tab ? tab_e : e);
    @(posedge wclk);
    #1;
    e = sb.pop_front();
    check_all(tag, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] prev_ptr;
    logic [2:0] prev_addr;
    logic       saw_addr_wrap, saw_ptr_wrap;
    int         cnt, rb;

    none = '{default: '0};
    //            winc rptr    clr  wptr    waddr f  af  lvl   ovf
    vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b0, 4'd1, 1'b0);
    vecs[1]  = mk(1'b1, 4'b0000, 1'b0, 4'b0011, 3'd2, 1'b0, 1'b0, 4'd2, 1'b0);
    vecs[2]  = mk(1'b1, 4'b0000, 1'b0, 4'b0010, 3'd3, 1'b0, 1'b0, 4'd3, 1'b0);
    vecs[3]  = mk(1'b1, 4'b0000, 1'b0, 4'b0110, 3'd4, 1'b0, 1'b0, 4'd4, 1'b0);
    vecs[4]  = mk(1'b1, 4'b0000, 1'b0, 4'b0111, 3'd5, 1'b0, 1'b0, 4'd5, 1'b0);
    vecs[5]  = mk(1'b1, 4'b0000, 1'b0, 4'b0101, 3'd6, 1'b0, 1'b1, 4'd6, 1'b0);
    vecs[6]  = mk(1'b1, 4'b0000, 1'b0, 4'b0100, 3'd7, 1'b0, 1'b1, 4'd7, 1'b0);
    vecs[7]  = mk(1'b1, 4'b0000, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0);
    vecs[8]  = mk(1'b1, 4'b0000, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
    vecs[9]  = mk(1'b1, 4'b0000, 1'b0, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b1);
    vecs[10] = mk(1'b0, 4'b0000, 1'b1, 4'b1100, 3'd0, 1'b1, 1'b1, 4'd8, 1'b0);
    vecs[11] = mk(1'b0, 4'b0001, 1'b0, 4'b1100, 3'd0, 1'b0, 1'b1, 4'd7, 1'b0);
    vecs[12] = mk(1'b1, 4'b0001, 1'b0, 4'b1101, 3'd1, 1'b1, 1'b1, 4'd8, 1'b0);
    vecs[13] = mk(1'b1, 4'b0001, 1'b1, 4'b1101, 3'd1, 1'b1, 1'b1, 4'd8, 1'b1);
    vecs[14] = mk(1'b0, 4'b0001, 1'b1, 4'b1101, 3'd1, 1'b1, 1'b1, 4'd8, 1'b0);

    m_bin = 0; m_rbin = 0; m_full = 1'b0; m_ovf = 1'b0;
    winc = 1'b0; woverflow_clr = 1'b0; wq2_rptr = 4'b0000;
    wrst = 1'b0;
    #1 wrst = 1'b1;
    #1 check_all("reset", none);
    @(negedge wclk);
    wrst = 1'b0;

    for (int i = 0; i < 15; i++) step(vecs[i].winc, vecs[i].rptr, vecs[i].clr, 1'b1, vecs[i].e, "tab");

    // Reset asserted mid-stream with winc held high, checked before any edge
    step(1'b1, 4'b1101, 1'b0, 1'b0, none, "pre_rst");
    step(1'b1, 4'b1101, 1'b0, 1'b0, none, "pre_rst");
    @(negedge wclk);
    winc = 1'b1;
    wrst = 1'b1;
    #1 check_all("mid_rst", none);
    m_bin = 0; m_full = 1'b0; m_ovf = 1'b0;
    winc = 1'b0; wq2_rptr = 4'b0000;
    @(negedge wclk);
    wrst = 1'b0;
    check("first_waddr", {5'h0, waddr}, 8'h00);

    // Wrap: read pointer trails the writes by three entries
    saw_addr_wrap = 1'b0; saw_ptr_wrap = 1'b0;
    prev_ptr = wptr; prev_addr = waddr; cnt = 0;
    for (int k = 0; k < 40; k++) begin
      rb = (cnt >= 3) ? (cnt - 3) % 16 : 0;
      step(1'b1, 4'(rb ^ (rb >> 1)), 1'b0, 1'b0, none, "wrap");
      cnt++;
      check("one_bit", 8'($countones(prev_ptr ^ wptr)), 8'd1);
      if (prev_addr == 3'd7 && waddr == 3'd0) saw_addr_wrap = 1'b1;
      if (prev_ptr == 4'b1000 && wptr == 4'b0000) saw_ptr_wrap = 1'b1;
      prev_ptr = wptr; prev_addr = waddr;
    end
    check("addr_wrap", {7'h0, saw_addr_wrap}, 8'h01);
    check("ptr_wrap",  {7'h0, saw_ptr_wrap},  8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 SHALL have parameter ADDR, default 3; address width; FIFO depth is 2^ADDR.
REQ-002 SHALL have parameter AFULL_THR, default 6; fill level at or above which walmost_full asserts; legal range 1..2^ADDR.
REQ-003 SHALL have port wclk  input  1  write-domain clock; all flops on rising edge.
REQ-004 SHALL have port wrst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port winc  input  1  write request from the producer.
REQ-006 SHALL have port wq2_rptr  input  ADDR+1  Gray read pointer, already two-flop synchronized into wclk.
REQ-007 SHALL have port woverflow_clr  input  1  clears the sticky overflow flag.
REQ-008 SHALL have port waddr  output  ADDR  write address to the dual-port memory.
REQ-009 SHALL have port wptr  output  ADDR+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-010 SHALL have port wfull  output  1  registered full flag.
REQ-011 SHALL have port walmost_full  output  1  registered almost-full flag.
REQ-012 SHALL have port wlevel  output  ADDR+1  registered fill level, 0..2^ADDR.
REQ-013 SHALL have port woverflow  output  1  sticky flag: write attempted while full.

Function
REQ-014 SHALL hold an internal ADDR+1-bit binary counter wbin; waddr = wbin[ADDR-1:0], combinational.
REQ-015 SHALL accept a write when winc=1 and wfull=0; wbinnext = wbin + accept, modulo 2^(ADDR+1).
REQ-016 SHALL register wptr <= wgraynext, where wgraynext = (wbinnext >> 1) XOR wbinnext; consecutive wptr values differ in exactly one bit.
REQ-017 SHALL register wfull <= (wgraynext == {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]}); full is visible on the same edge as the write that fills the FIFO.
REQ-018 SHALL convert wq2_rptr to binary rq2bin and register wlevel <= wbinnext - rq2bin, modulo 2^(ADDR+1).
REQ-019 SHALL register walmost_full <= (wbinnext - rq2bin >= AFULL_THR).
REQ-020 SHALL ignore winc while wfull=1: wbin, wptr and waddr unchanged, memory write suppressed upstream by wfull.
REQ-021 SHALL set woverflow on the edge after winc=1 with wfull=1; clear it on woverflow_clr=1; simultaneous set and clear: set wins.
REQ-022 SHALL deassert wfull pessimistically: only after an advanced wq2_rptr is sampled (synchronizer latency adds no false "not full").
REQ-023 SHALL wrap wbin from 2^(ADDR+1)-1 to 0 with no special handling.

Reset
REQ-024 SHALL on wrst=1 immediately force wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0, independent of wclk.
REQ-025 SHALL, on reset asserted mid-operation, discard all pointer state; first accepted write after release writes waddr=0.

Structure
REQ-026 SHALL take the default ADDR and AFULL_THR constants from the shared fifo package also used by the read-side pointer block.
REQ-027 SHALL instantiate one sub-module gray2bin (parameterised width, purely combinational) for wq2_rptr conversion; the read side reuses it.

Verification
REQ-028 SHALL verify reset: wrst=1 mid-stream with winc=1 -> wptr=0000, waddr=0, wfull=0, wlevel=0, woverflow=0 without clock edge.
REQ-029 SHALL verify fill: wq2_rptr=0000, 8 consecutive winc -> after 8th edge wptr=1100, wlevel=8, wfull=1; walmost_full=1 from the 6th edge.
REQ-030 SHALL verify overflow: full, winc=1 for 2 cycles -> wptr stays 1100, woverflow=1 next edge; woverflow_clr=1 with winc=0 -> woverflow=0.
REQ-031 SHALL verify drain release: while full, wq2_rptr 0000->0001 -> next edge wfull=0, wlevel=7; next winc -> wptr=1101, wfull=1.
REQ-032 SHALL verify wrap: 40 writes interleaved with wq2_rptr tracking -> waddr 7->0 and wptr 1000->0000 wraps, every wptr change is one bit.
REQ-033 SHALL verify clear/set race: woverflow_clr=1 and winc=1 with wfull=1 same cycle -> woverflow stays 1.
